// File: rtl/vga_mon_pkg.sv
// Shared constants and FSM encoding for the VGA sync monitor.
package vga_mon_pkg;

    localparam int unsigned H_ACT_START = 144;
    localparam int unsigned H_ACT_END   = 784;
    localparam int unsigned V_ACT_START = 35;
    localparam int unsigned V_ACT_END   = 515;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/vga_mon_edge_sync.sv
// Two-flop synchronizer with registered rise/fall pulses; level is aligned with the pulses.
module vga_mon_edge_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_l,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            meta  <= RESET_VAL;
            sync  <= RESET_VAL;
            level <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end

endmodule

// File: rtl/vga_sync_monitor.sv
// Recovers pixel/line position from VGA syncs, checks timing and tracks lock.
// Optional bright-window check enabled by defining VGA_MON_BRIGHT_CHECK_EN.
module vga_sync_monitor
    import vga_mon_pkg::*;
#(
    parameter int unsigned CLKS_PER_PIXEL = 4,
    parameter int unsigned H_TOTAL        = 800,
    parameter int unsigned V_TOTAL        = 525,
    parameter int unsigned HSYNC_W        = 96,
    parameter int unsigned VSYNC_W        = 2
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       bright,
    output logic [9:0] hCount_rx,
    output logic [9:0] vCount_rx,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       err_h,
    output logic       err_v,
    output logic       err_b,
    output logic [7:0] err_count
);

    localparam int unsigned LINE_CLKS  = H_TOTAL * CLKS_PER_PIXEL;
    localparam int unsigned HSYNC_CLKS = HSYNC_W * CLKS_PER_PIXEL;
    localparam int unsigned DIV_W      = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam int unsigned HCNT_W     = $clog2(LINE_CLKS + 1);

    logic h_lvl, h_rise, h_fall;
    logic v_lvl, v_rise, v_fall;
    logic b_lvl, b_rise, b_fall;

    vga_mon_edge_sync #(.RESET_VAL(1'b1)) u_hsync (
        .clk(clk), .rst_l(rst_l), .din(hSync), .level(h_lvl), .rise(h_rise), .fall(h_fall)
    );
    vga_mon_edge_sync #(.RESET_VAL(1'b1)) u_vsync (
        .clk(clk), .rst_l(rst_l), .din(vSync), .level(v_lvl), .rise(v_rise), .fall(v_fall)
    );
    vga_mon_edge_sync #(.RESET_VAL(1'b0)) u_bright (
        .clk(clk), .rst_l(rst_l), .din(bright), .level(b_lvl), .rise(b_rise), .fall(b_fall)
    );

    logic [DIV_W-1:0]  div;
    logic [HCNT_W-1:0] h_cnt;
    logic              h_armed, h_over, v_armed;
    logic [9:0]        v_next;
    logic              raw_h, raw_v, raw_b, any_err;
    logic              frame_err, prev_bad;
    mon_state_t        state;
    logic              unused_sigs;

    // A vSync rise usually lands on an hSync fall, so it is judged against the post-edge line count.
    always_comb begin
        v_next = vCount_rx;
        if (v_fall)
            v_next = '0;
        else if (h_fall)
            v_next = vCount_rx + 10'd1;
    end

    always_comb begin
        raw_h = 1'b0;
        if (h_armed && !h_over) begin
            if (h_fall)
                raw_h = (h_cnt != HCNT_W'(LINE_CLKS - 1));
            else
                raw_h = (h_cnt == HCNT_W'(LINE_CLKS - 1));
        end
        if (h_armed && h_rise && (h_cnt != HCNT_W'(HSYNC_CLKS - 1)))
            raw_h = 1'b1;
        raw_v = v_armed && ((v_fall && (vCount_rx != 10'(V_TOTAL - 1))) ||
                            (v_rise && (v_next != 10'(VSYNC_W))));
        if (state == SEARCH) begin
            raw_h = 1'b0;
            raw_v = 1'b0;
        end
    end

`ifdef VGA_MON_BRIGHT_CHECK_EN
    logic in_window;
    assign in_window = (hCount_rx >= 10'(H_ACT_START)) && (hCount_rx < 10'(H_ACT_END)) &&
                       (vCount_rx >= 10'(V_ACT_START)) && (vCount_rx < 10'(V_ACT_END));
    assign raw_b       = pix_valid && (b_lvl != in_window) && (state != SEARCH);
    assign unused_sigs = &{1'b0, h_lvl, v_lvl, b_rise, b_fall};
`else
    assign raw_b       = 1'b0;
    assign unused_sigs = &{1'b0, h_lvl, v_lvl, b_lvl, b_rise, b_fall};
`endif

    assign any_err = raw_h | raw_v | raw_b;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            div       <= '0;
            hCount_rx <= '0;
            vCount_rx <= '0;
            pix_valid <= 1'b0;
            h_cnt     <= '0;
            h_armed   <= 1'b0;
            h_over    <= 1'b0;
            v_armed   <= 1'b0;
            err_h     <= 1'b0;
            err_v     <= 1'b0;
            err_b     <= 1'b0;
            err_count <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (h_fall) begin
                div       <= '0;
                hCount_rx <= '0;
            end else if (div == DIV_W'(CLKS_PER_PIXEL - 1)) begin
                div       <= '0;
                pix_valid <= 1'b1;
                if (hCount_rx != 10'(H_TOTAL - 1))
                    hCount_rx <= hCount_rx + 10'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
            vCount_rx <= v_next;

            // h_over marks an overrun already reported, so the late fall stays silent.
            if (h_fall) begin
                h_cnt   <= '0;
                h_armed <= 1'b1;
                h_over  <= 1'b0;
            end else begin
                if (h_cnt != HCNT_W'(LINE_CLKS - 1))
                    h_cnt <= h_cnt + HCNT_W'(1);
                if (h_armed && (h_cnt == HCNT_W'(LINE_CLKS - 1)))
                    h_over <= 1'b1;
            end
            if (v_fall)
                v_armed <= 1'b1;

            err_h <= raw_h;
            err_v <= raw_v;
            err_b <= raw_b;
            if ((err_h || err_v || err_b) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            prev_bad    <= 1'b0;
        end else begin
            frame_start <= v_fall && (state == LOCKED);
            case (state)
                SEARCH: begin
                    if (v_fall) begin
                        state     <= ACQUIRE;
                        frame_err <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (v_fall) begin
                        frame_err <= 1'b0;
                        prev_bad  <= 1'b0;
                        if (!(frame_err || any_err)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (any_err) begin
                        frame_err <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (v_fall) begin
                        frame_err <= 1'b0;
                        if (frame_err || any_err) begin
                            if (prev_bad) begin
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                prev_bad <= 1'b0;
                            end else begin
                                prev_bad <= 1'b1;
                            end
                        end else begin
                            prev_bad <= 1'b0;
                        end
                    end else if (any_err) begin
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
